// File: rtl/intctl_multi.sv
// intctl_multi: multi-channel, multi-level Unibus interrupt requester.
// Channels bound to fixed levels BR4..BR7 share one bus-master port; the
// block arbitrates, runs BR/BG -> SACK -> BBSY/INTR/vector, and returns a
// one-cycle acknowledge to the serviced channel when SSYN arrives.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transaction; arbitrate among requesting channels
// ST_REQ    | BR asserted for the winner; deglitching the bus grant
// ST_SACK   | grant accepted, SACK asserted; waiting for the bus to go idle
// ST_MASTER | BBSY/INTR/vector driven; waiting for SSYN from the CPU
module intctl_multi #(
  parameter int          NCHAN      = 4,
  parameter logic [15:0] LEVELS     = 16'hFFFF,
  parameter int          GNTDLY     = 4,
  parameter int          ROUNDROBIN = 0
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [NCHAN-1:0]     req_in_h,
  input  logic [6*NCHAN-1:0]   vec_in,
  input  logic                 bbsy_in_h,
  input  logic [3:0]           bg_in_l,
  input  logic                 init_in_h,
  input  logic                 ssyn_in_h,
  output logic                 bbsy_out_h,
  output logic [3:0]           br_out_h,
  output logic [15:0]          d_out_h,
  output logic                 intr_out_h,
  output logic                 sack_out_h,
  output logic [NCHAN-1:0]     ack_out_h,
  output logic                 busy_out_h
);

  localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SACK, ST_MASTER} state_t;

  state_t           state_q, state_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [CHW-1:0]   rrptr_q, rrptr_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       br_q, br_d;
  logic             sack_q, sack_d;
  logic             bbsy_q, bbsy_d;
  logic             intr_q, intr_d;
  logic [15:0]      d_q, d_d;
  logic [NCHAN-1:0] ack_q, ack_d;

  logic [1:0]       chan_lvl [NCHAN];
  logic [NCHAN-1:0] cand;
  logic [NCHAN-1:0] match;
  logic             any_cand;
  logic [1:0]       win_lvl;
  logic [CHW-1:0]   win_ch;
  logic             req_cur;
  logic [5:0]       vec_cur;
  logic [NCHAN-1:0] ch_onehot;

  // Candidate set and winner selection; a channel whose grant line is already
  // low is skipped so a grant propagating to a downstream device is not stolen.
  always_comb begin
    logic           hi_found;
    logic [CHW-1:0] hi_ch;
    logic [CHW-1:0] lo_ch;
    hi_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    win_lvl  = 2'd0;
    for (int i = 0; i < NCHAN; i++) begin
      chan_lvl[i] = LEVELS[2*i +: 2];
      cand[i]     = req_in_h[i] & bg_in_l[LEVELS[2*i +: 2]];
    end
    any_cand = |cand;
    // Ascending scan: the last matching level is the highest one.
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (cand[i] && (chan_lvl[i] == 2'(l))) win_lvl = 2'(l);
      end
    end
    for (int i = 0; i < NCHAN; i++) begin
      match[i] = cand[i] && (chan_lvl[i] == win_lvl);
    end
    // Descending scans leave the lowest matching index in each result.
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (match[i]) lo_ch = CHW'(i);
      if (match[i] && (CHW'(i) >= rrptr_q)) begin
        hi_found = 1'b1;
        hi_ch    = CHW'(i);
      end
    end
    if (ROUNDROBIN != 0) win_ch = hi_found ? hi_ch : lo_ch;
    else                 win_ch = lo_ch;
  end

  // Per-channel views of the latched channel, built with constant indices.
  always_comb begin
    req_cur   = 1'b0;
    vec_cur   = 6'd0;
    ch_onehot = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (ch_q == CHW'(i)) begin
        req_cur      = req_in_h[i];
        vec_cur      = vec_in[6*i +: 6];
        ch_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and output-register logic; bus INIT overrides every state.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    rrptr_d = rrptr_q;
    br_d    = br_q;
    sack_d  = sack_q;
    bbsy_d  = bbsy_q;
    intr_d  = intr_q;
    d_d     = d_q;
    ack_d   = '0;
    if (init_in_h) begin
      state_d = ST_IDLE;
      ch_d    = '0;
      lvl_d   = 2'd0;
      cnt_d   = 3'd0;
      rrptr_d = '0;
      br_d    = 4'd0;
      sack_d  = 1'b0;
      bbsy_d  = 1'b0;
      intr_d  = 1'b0;
      d_d     = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_cand) begin
            ch_d    = win_ch;
            lvl_d   = win_lvl;
            br_d    = 4'b0001 << win_lvl;
            cnt_d   = 3'd0;
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (!req_cur) begin
            br_d    = 4'd0;
            state_d = ST_IDLE;
          end else if (bg_in_l[lvl_q]) begin
            cnt_d = 3'd0;
          end else if (cnt_q != 3'(GNTDLY)) begin
            cnt_d = cnt_q + 3'd1;
          end else begin
            br_d    = 4'd0;
            sack_d  = 1'b1;
            state_d = ST_SACK;
          end
        end
        ST_SACK: begin
          if (!bbsy_in_h && bg_in_l[lvl_q] && !ssyn_in_h) begin
            sack_d = 1'b0;
            if (req_cur) begin
              bbsy_d  = 1'b1;
              intr_d  = 1'b1;
              d_d     = {8'b0, vec_cur, 2'b00};
              state_d = ST_MASTER;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_MASTER: begin
          // A request drop here is deliberately ignored: the vector is on the bus.
          if (ssyn_in_h) begin
            bbsy_d  = 1'b0;
            intr_d  = 1'b0;
            d_d     = 16'd0;
            ack_d   = ch_onehot;
            rrptr_d = (ch_q == CHW'(NCHAN - 1)) ? '0 : ch_q + 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      lvl_q   <= 2'd0;
      cnt_q   <= 3'd0;
      rrptr_q <= '0;
      br_q    <= 4'd0;
      sack_q  <= 1'b0;
      bbsy_q  <= 1'b0;
      intr_q  <= 1'b0;
      d_q     <= 16'd0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      rrptr_q <= rrptr_d;
      br_q    <= br_d;
      sack_q  <= sack_d;
      bbsy_q  <= bbsy_d;
      intr_q  <= intr_d;
      d_q     <= d_d;
      ack_q   <= ack_d;
    end
  end

  assign br_out_h   = br_q;
  assign sack_out_h = sack_q;
  assign bbsy_out_h = bbsy_q;
  assign intr_out_h = intr_q;
  assign d_out_h    = d_q;
  assign ack_out_h  = ack_q;
  assign busy_out_h = (state_q != ST_IDLE);

endmodule
